bus_dev_port: RTL and testbench

BUS_DEV_PORT -- requirements
Module: bus_dev_port

---
 rtl/bus_dev_port_pkg.sv | 17 +
 rtl/fifo_sync.sv | 51 +++++
 rtl/bus_dev_port.sv | 81 ++++++++
 tb/tb_bus_dev_port.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_dev_port_pkg.sv
// Shared definitions for the bus device port: address field, broadcast value
// and destination extraction.
package bus_dev_port_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned PKT_MAX_W = 256;

  localparam logic [ADDR_W-1:0] BROADCAST_DEFAULT = 8'hFF;

  // Destination lives in the top ADDR_W bits of a pkt_w-bit packet
  // (the packet is passed zero-extended to PKT_MAX_W).
  function automatic logic [ADDR_W-1:0] get_dest(input logic [PKT_MAX_W-1:0] pkt,
                                                 input int unsigned         pkt_w);
    return ADDR_W'(pkt >> (pkt_w - ADDR_W));
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock show-ahead FIFO; a write while full succeeds only alongside
// a read in the same cycle.
module fifo_sync #(
  parameter int unsigned width = 32,
  parameter int unsigned depth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [width-1:0] din,
  input  logic             rd,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_rd;
  logic             do_wr;

  assign full  = (cnt == CW'(depth));
  assign empty = (cnt == '0);
  assign dout  = mem[rd_ptr];

  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_wr) - CW'(do_rd);
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_wr && !reset) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bus_dev_port.sv
// Bus device port: TX queue toward the bus arbiter, address-filtered RX queue
// toward the host, drop counters and a sticky underflow error.
module bus_dev_port
  import bus_dev_port_pkg::*;
#(
  parameter int unsigned       pckg_sz   = 32,
  parameter int unsigned       depth     = 8,
  parameter logic [ADDR_W-1:0] id        = 8'd0,
  parameter logic [ADDR_W-1:0] broadcast = BROADCAST_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  input  logic               rx_rd,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_empty,
  output logic [7:0]         rx_ovf_cnt,
  output logic [7:0]         rx_filt_cnt,
  output logic               err
);

  logic              tx_empty;
  logic              rx_full;
  logic [ADDR_W-1:0] dest;
  logic              addr_hit;
  logic              rx_wr;
  logic              rx_drop;
  logic              underflow;

  fifo_sync #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (tx_wr & ~tx_full),
    .din   (tx_data),
    .rd    (pop),
    .dout  (D_pop),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign pndng = ~tx_empty;

  assign dest     = get_dest(PKT_MAX_W'(D_push), pckg_sz);
  assign addr_hit = (dest == id) || (dest == broadcast);
  assign rx_wr    = push & addr_hit;
  // A full RX still takes the packet when the host drains an entry this cycle.
  assign rx_drop  = rx_wr & rx_full & ~rx_rd;

  fifo_sync #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (rx_wr),
    .din   (D_push),
    .rd    (rx_rd),
    .dout  (rx_data),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign underflow = (pop & tx_empty) | (rx_rd & rx_empty);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ovf_cnt  <= '0;
      rx_filt_cnt <= '0;
      err         <= 1'b0;
    end else begin
      if (push && !addr_hit && rx_filt_cnt != 8'hFF) rx_filt_cnt <= rx_filt_cnt + 8'd1;
      if (rx_drop && rx_ovf_cnt != 8'hFF)            rx_ovf_cnt  <= rx_ovf_cnt + 8'd1;
      if (underflow)                                 err         <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_dev_port.sv
// Self-checking bench for bus_dev_port: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_bus_dev_port;

  localparam int unsigned PW = 32;
  localparam int unsigned DP = 8;
  localparam logic [7:0]  MY_ID = 8'd3;
  localparam logic [7:0]  BC    = 8'hFF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pndng;
  logic [PW-1:0] D_pop;
  logic          pop = 1'b0;
  logic          push = 1'b0;
  logic [PW-1:0] D_push = '0;
  logic          tx_wr = 1'b0;
  logic [PW-1:0] tx_data = '0;
  logic          tx_full;
  logic          rx_rd = 1'b0;
  logic [PW-1:0] rx_data;
  logic          rx_empty;
  logic [7:0]    rx_ovf_cnt;
  logic [7:0]    rx_filt_cnt;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] tx_q[$];
  logic [PW-1:0] rx_q[$];
  int            m_ovf = 0;
  int            m_filt = 0;
  bit            m_err = 1'b0;

  bus_dev_port #(.pckg_sz(PW), .depth(DP), .id(MY_ID), .broadcast(BC)) dut (
    .clk         (clk),
    .reset       (reset),
    .pndng       (pndng),
    .D_pop       (D_pop),
    .pop         (pop),
    .push        (push),
    .D_push      (D_push),
    .tx_wr       (tx_wr),
    .tx_data     (tx_data),
    .tx_full     (tx_full),
    .rx_rd       (rx_rd),
    .rx_data     (rx_data),
    .rx_empty    (rx_empty),
    .rx_ovf_cnt  (rx_ovf_cnt),
    .rx_filt_cnt (rx_filt_cnt),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one clock edge of behaviour, using pre-edge inputs and state.
  task automatic model_edge();
    bit tx_rd_ok, tx_wr_ok, rx_rd_ok, addr_ok, rx_wr_ok;
    if (reset) begin
      tx_q.delete();
      rx_q.delete();
      m_ovf  = 0;
      m_filt = 0;
      m_err  = 1'b0;
      return;
    end
    tx_rd_ok = pop && tx_q.size() > 0;
    tx_wr_ok = tx_wr && tx_q.size() < DP;
    if (pop && tx_q.size() == 0) m_err = 1'b1;
    rx_rd_ok = rx_rd && rx_q.size() > 0;
    if (rx_rd && rx_q.size() == 0) m_err = 1'b1;
    addr_ok  = (D_push[31:24] == MY_ID) || (D_push[31:24] == BC);
    rx_wr_ok = push && addr_ok && (rx_q.size() < DP || rx_rd_ok);
    if (push && !addr_ok && m_filt < 255) m_filt++;
    if (push && addr_ok && !rx_wr_ok && m_ovf < 255) m_ovf++;
    if (tx_rd_ok) void'(tx_q.pop_front());
    if (tx_wr_ok) tx_q.push_back(tx_data);
    if (rx_rd_ok) void'(rx_q.pop_front());
    if (rx_wr_ok) rx_q.push_back(D_push);
  endtask

  task automatic check_all();
    chk("pndng",    32'(pndng),    32'(tx_q.size() != 0));
    chk("tx_full",  32'(tx_full),  32'(tx_q.size() == DP));
    chk("rx_empty", 32'(rx_empty), 32'(rx_q.size() == 0));
    chk("ovf_cnt",  32'(rx_ovf_cnt),  32'(m_ovf));
    chk("filt_cnt", 32'(rx_filt_cnt), 32'(m_filt));
    chk("err",      32'(err),      32'(m_err));
    if (tx_q.size() != 0) chk("D_pop",   D_pop,   tx_q[0]);
    if (rx_q.size() != 0) chk("rx_data", rx_data, rx_q[0]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic r, input logic tw, input logic [31:0] td,
                       input logic p, input logic ps, input logic [31:0] dp,
                       input logic rr);
    reset = r; tx_wr = tw; tx_data = td; pop = p; push = ps; D_push = dp; rx_rd = rr;
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [31:0] pk;
    logic [7:0]  dst;

    // Reset state
    do_reset();
    do_reset();
    chk("rst_pndng", 32'(pndng), 32'd0);
    chk("rst_rx_empty", 32'(rx_empty), 32'd1);

    // Three TX packets in, three out in order
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0, '0, 1'b0);
    chk("tx3_pndng", 32'(pndng), 32'd1);
    chk("tx3_head", D_pop, 32'hA000_0000);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("tx3_drained", 32'(pndng), 32'd0);

    // Fill TX, then write+pop on a full FIFO: the write is dropped
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b0, '0, 1'b0);
    chk("tx_full8", 32'(tx_full), 32'd1);
    drive(1'b0, 1'b1, 32'hBEEF_0009, 1'b1, 1'b0, '0, 1'b0);
    chk("tx_after_wp", 32'(tx_full), 32'd0);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("tx_count7", 32'(pndng), 32'd0);

    // Address filter
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h0300_0001, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'hFF00_0002, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h0500_0003, 1'b0);
    chk("filt_one", 32'(rx_filt_cnt), 32'd1);
    chk("filt_head", rx_data, 32'h0300_0001);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    chk("filt_rx_empty", 32'(rx_empty), 32'd1);

    // RX overflow, then simultaneous read+push on a full RX
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h0300_0100 + 32'(i), 1'b0);
    chk("ovf_two", 32'(rx_ovf_cnt), 32'd2);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h0300_0DDD, 1'b1);
    chk("ovf_rdpush", 32'(rx_ovf_cnt), 32'd2);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

    // Underflow error is sticky until reset
    do_reset();
    drive(1'b0, 1'b1, 32'h0700_0042, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) idle();
    chk("err_sticky", 32'(err), 32'd1);

    // Reset with 4 queued in each FIFO
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b1, 32'h0300_0200 + 32'(i), 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h0900_0000, 1'b1);
    do_reset();
    chk("rst4_pndng", 32'(pndng), 32'd0);
    chk("rst4_rx_empty", 32'(rx_empty), 32'd1);
    chk("rst4_err", 32'(err), 32'd0);
    chk("rst4_filt", 32'(rx_filt_cnt), 32'd0);

    // Counter saturation
    for (int i = 0; i < 300; i++) drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h5500_0000 + 32'(i), 1'b0);
    chk("filt_sat", 32'(rx_filt_cnt), 32'd255);
    for (int i = 0; i < 270; i++) drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 32'hFF00_0000 + 32'(i), 1'b0);
    chk("ovf_sat", 32'(rx_ovf_cnt), 32'd255);
    do_reset();

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 3))
        0, 3:    dst = MY_ID;
        1:       dst = BC;
        default: dst = 8'($urandom);
      endcase
      pk = {dst, 24'($urandom)};
      drive(1'($urandom_range(0, 199) == 0),
            1'($urandom_range(0, 1)), $urandom(),
            1'($urandom_range(0, 9) < 4),
            1'($urandom_range(0, 1)), pk,
            1'($urandom_range(0, 9) < 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
